// File: rtl/ntt_pkg.sv
// Shared constants, state encoding and conf-code helpers
// for the mixed-radix 512-point NTT/INTT scheduler.
package ntt_pkg;

  localparam int R4_CYCLES = 512;
  localparam int R2_CYCLES = 128;
  localparam int DRAIN4    = 14;
  localparam int DRAIN2    = 8;
  localparam int WD_MARGIN = 16;
  localparam int CNT_W     = $clog2(R4_CYCLES + WD_MARGIN + 1);

  localparam logic [3:0] IDLE             = 4'b0000;
  localparam logic [3:0] RADIX2_NTT       = 4'b0001;
  localparam logic [3:0] RADIX4_NTT       = 4'b0010;
  localparam logic [3:0] DONE_RADIX2_NTT  = 4'b0011;
  localparam logic [3:0] DONE_RADIX4_NTT  = 4'b0100;
  localparam logic [3:0] RADIX4_INTT      = 4'b0101;
  localparam logic [3:0] RADIX2_INTT      = 4'b0110;
  localparam logic [3:0] DONE_RADIX2_INTT = 4'b0111;
  localparam logic [3:0] DONE_RADIX4_INTT = 4'b1000;

  localparam logic [2:0] DONE_R2 = 3'b001;
  localparam logic [2:0] DONE_R4 = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN_A,
    S_DRAIN_A,
    S_RUN_B,
    S_DRAIN_B
  } state_e;

  function automatic logic [3:0] run_code(
    input logic inv,
    input logic r4
  );
    if (inv) return r4 ? RADIX4_INTT : RADIX2_INTT;
    return r4 ? RADIX4_NTT : RADIX2_NTT;
  endfunction

  function automatic logic [3:0] drain_code(
    input logic inv,
    input logic r4
  );
    if (inv) return r4 ? DONE_RADIX4_INTT : DONE_RADIX2_INTT;
    return r4 ? DONE_RADIX4_NTT : DONE_RADIX2_NTT;
  endfunction

endpackage

// File: rtl/ntt_op_scheduler_phase_timer.sv
// Saturating up-counter with synchronous clear and
// terminal compare; shared by run, watchdog and drain timing.
module phase_timer
  import ntt_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] term,
  output logic         hit
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr)           count_d = '0;
    else if (!(&count_q)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign hit = (count_q == term);

endmodule

// File: rtl/ntt_op_scheduler.sv
// Top-level sequencer: orders radix-4/radix-2 phases, holds
// DONE codes while the butterfly pipeline drains.
module ntt_op_scheduler
  import ntt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       inverse,
  input  logic       abort,
  input  logic [2:0] done_flag,
  output logic [3:0] conf,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] phase
);

  state_e           state_q, state_d;
  logic [3:0]       conf_q, conf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       phase_q, phase_d;
  logic             inv_q, inv_d;
  logic             tclr;
  logic             hit;
  logic             r4;
  logic             go;
  logic [CNT_W-1:0] term;

  phase_timer #(.W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst),
    .clr   (tclr),
    .term  (term),
    .hit   (hit)
  );

  always_comb begin
    state_d = state_q;
    conf_d  = conf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    phase_d = phase_q;
    inv_d   = inv_q;
    tclr    = 1'b0;
    r4      = 1'b0;
    go      = 1'b0;
    term    = '0;
    unique case (state_q)
      S_IDLE: begin
        tclr = 1'b1;
        if (start) begin
          state_d = S_RUN_A;
          inv_d   = inverse;
          conf_d  = run_code(inverse, !inverse);
          busy_d  = 1'b1;
          phase_d = 2'd1;
        end
      end
      S_RUN_A, S_RUN_B: begin
        r4 = (state_q == S_RUN_A) ^ inv_q;
        // INTT is purely timed; NTT waits for the flag under a watchdog
        if (inv_q) begin
          term = r4 ? CNT_W'(R4_CYCLES - 1) : CNT_W'(R2_CYCLES - 1);
          go   = hit;
        end else begin
          term = r4 ? CNT_W'(R4_CYCLES + WD_MARGIN)
                    : CNT_W'(R2_CYCLES + WD_MARGIN);
          go   = (done_flag == (r4 ? DONE_R4 : DONE_R2));
        end
        if (go) begin
          state_d = (state_q == S_RUN_A) ? S_DRAIN_A : S_DRAIN_B;
          conf_d  = drain_code(inv_q, r4);
          phase_d = 2'd3;
          tclr    = 1'b1;
        end else if (hit) begin
          state_d = S_IDLE;
          conf_d  = IDLE;
          busy_d  = 1'b0;
          phase_d = 2'd0;
          err_d   = 1'b1;
          tclr    = 1'b1;
        end
      end
      S_DRAIN_A, S_DRAIN_B: begin
        r4   = (state_q == S_DRAIN_A) ^ inv_q;
        term = r4 ? CNT_W'(DRAIN4 - 1) : CNT_W'(DRAIN2 - 1);
        if (hit) begin
          tclr = 1'b1;
          if (state_q == S_DRAIN_A) begin
            state_d = S_RUN_B;
            conf_d  = run_code(inv_q, !r4);
            phase_d = 2'd2;
          end else begin
            state_d = S_IDLE;
            conf_d  = IDLE;
            busy_d  = 1'b0;
            phase_d = 2'd0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        conf_d  = IDLE;
        busy_d  = 1'b0;
        phase_d = 2'd0;
        tclr    = 1'b1;
      end
    endcase
    if (abort) begin
      state_d = S_IDLE;
      conf_d  = IDLE;
      busy_d  = 1'b0;
      phase_d = 2'd0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      inv_d   = inv_q;
      tclr    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      conf_q  <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      phase_q <= 2'd0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      conf_q  <= conf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      phase_q <= phase_d;
      inv_q   <= inv_d;
    end
  end

  assign conf  = conf_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign phase = phase_q;

endmodule

// File: tb/tb_ntt_op_scheduler.sv
// Directed, table-driven bench for ntt_op_scheduler.
// Inputs and samples change on the falling edge.
module tb_ntt_op_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       inverse = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] done_flag = 3'b000;
  logic [3:0] conf;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] phase;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [3:0] code;
    int         len;
    logic [2:0] flag;
    logic [1:0] ph;
  } seg_t;

  seg_t tbl [8];

  ntt_op_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .inverse   (inverse),
    .abort     (abort),
    .done_flag (done_flag),
    .conf      (conf),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Expects `code` on conf for exactly `len` cycles; drives `flag`
  // on the last cycle as the address FSM would.
  task automatic run_seg(input logic [3:0] code, input int len,
                         input logic [2:0] flag, input logic [1:0] ph,
                         input bit noise, input string name);
    int bad = 0;
    logic [3:0] first = code;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (conf !== code || busy !== 1'b1 || phase !== ph ||
          done !== 1'b0 || err !== 1'b0) begin
        if (bad == 0) first = conf;
        bad++;
      end
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      done_flag = (i == len - 1) ? flag : 3'b000;
      if (noise && code == 4'b0010 && i < len - 1 && (i % 5) == 2)
        done_flag = 3'b001;
    end
    total++;
    if (bad == 0) passed++;
    else $display("FAIL %s: %0d bad cycles, conf got %b, expected %b x%0d",
                  name, bad, first, code, len);
  endtask

  task automatic finish_check(input string name);
    @(negedge clk);
    chk({name, "_end"}, {23'd0, conf, busy, done, err, phase},
        {23'd0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0});
    start = 1'b0;
    done_flag = 3'b000;
    @(negedge clk);
    chk({name, "_pulse"}, {30'd0, done, err}, 32'd0);
  endtask

  task automatic run_full(input int base, input bit noise,
                          input string name);
    for (int s = 0; s < 4; s++)
      run_seg(tbl[base+s].code, tbl[base+s].len, tbl[base+s].flag,
              tbl[base+s].ph, noise, $sformatf("%s_seg%0d", name, s));
    finish_check(name);
  endtask

  task automatic start_op(input logic inv);
    start = 1'b1;
    inverse = inv;
  endtask

  initial begin
    tbl[0] = '{4'b0010, 512, 3'b010, 2'd1};
    tbl[1] = '{4'b0100, 14,  3'b000, 2'd3};
    tbl[2] = '{4'b0001, 128, 3'b001, 2'd2};
    tbl[3] = '{4'b0011, 8,   3'b000, 2'd3};
    tbl[4] = '{4'b0110, 128, 3'b000, 2'd1};
    tbl[5] = '{4'b0111, 8,   3'b000, 2'd3};
    tbl[6] = '{4'b0101, 512, 3'b000, 2'd2};
    tbl[7] = '{4'b1000, 14,  3'b000, 2'd3};

    repeat (3) @(negedge clk);
    chk("reset_state", {23'd0, conf, busy, done, err, phase}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_hold", {23'd0, conf, busy, done, err, phase}, 32'd0);

    start_op(1'b0);
    run_full(0, 1'b0, "ntt");

    start_op(1'b1);
    run_full(4, 1'b0, "intt");

    start_op(1'b0);
    run_seg(4'b0010, 529, 3'b000, 2'd1, 1'b0, "wd_run");
    @(negedge clk);
    chk("wd_err", {23'd0, conf, busy, done, err, phase},
        {23'd0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0});
    @(negedge clk);
    chk("wd_err_pulse", {30'd0, done, err}, 32'd0);

    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    chk("start_abort_same", {27'd0, conf, busy}, 32'd0);
    start = 1'b0;
    abort = 1'b0;

    start_op(1'b0);
    run_seg(4'b0010, 512, 3'b010, 2'd1, 1'b0, "ab_runa");
    run_seg(4'b0100, 4, 3'b000, 2'd3, 1'b0, "ab_drain4");
    @(negedge clk);
    chk("ab_5th_drain", {28'd0, conf}, {28'd0, 4'b0100});
    abort = 1'b1;
    @(negedge clk);
    chk("ab_idle", {23'd0, conf, busy, done, err, phase}, 32'd0);
    abort = 1'b0;
    start_op(1'b0);
    @(negedge clk);
    chk("ab_restart", {27'd0, conf, busy}, {27'd0, 4'b0010, 1'b1});
    start = 1'b0;
    run_seg(4'b0010, 511, 3'b010, 2'd1, 1'b0, "ab_re_runa");
    for (int s = 1; s < 4; s++)
      run_seg(tbl[s].code, tbl[s].len, tbl[s].flag, tbl[s].ph, 1'b0,
              $sformatf("ab_re_seg%0d", s));
    finish_check("ab_re");

    start_op(1'b0);
    run_seg(4'b0010, 512, 3'b010, 2'd1, 1'b0, "rst_runa");
    run_seg(4'b0100, 14, 3'b000, 2'd3, 1'b0, "rst_drain4");
    run_seg(4'b0001, 10, 3'b000, 2'd2, 1'b0, "rst_runb");
    #2 rst = 1'b0;
    #1 chk("async_rst", {25'd0, conf, busy, phase}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start_op(1'b0);
    run_full(0, 1'b0, "post_rst");

    start_op(1'b0);
    run_full(0, 1'b1, "noise");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ntt_op_scheduler.md
Name: ntt_op_scheduler

Overview:
- Top-level sequencer for the mixed-radix 512-point NTT/INTT engine.
- Accepts one start request and drives the 4-bit conf code into the address/control FSM.
- Forward NTT runs all radix-4 stages first, then the final radix-2 stage. Inverse runs radix-2 first, then radix-4.
- Between phases, holds the DONE_* code so the butterfly pipeline drains before the next phase reads memory. Reports busy, completion and watchdog error to the host.

Parameters:
- R4_CYCLES, 512, issue cycles of the full radix-4 phase (4 stages x 128).
- R2_CYCLES, 128, issue cycles of the radix-2 phase.
- DRAIN4, 14, cycles the DONE_RADIX4_* code is held (radix-4 write-back latency).
- DRAIN2, 8, cycles the DONE_RADIX2_* code is held (radix-2 write-back latency).
- WD_MARGIN, 16, extra cycles past the expected phase length before a missing done_flag is an error.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in S_IDLE
- inverse  in  1  0 = NTT, 1 = INTT; latched with start
- abort  in  1  synchronous abort; forces S_IDLE next cycle
- done_flag  in  3  FSM completion: 3'b001 radix-2 NTT done, 3'b010 radix-4 NTT done
- conf  out  4  operation code to FSM
- busy  out  1  high from the cycle after an accepted start until done/err/abort
- done  out  1  one-cycle pulse when the second drain completes
- err  out  1  one-cycle pulse on watchdog expiry
- phase  out  2  0 idle, 1 first compute, 2 second compute, 3 drain (debug)

Behaviour:
- Reset (rst=0, async): state S_IDLE; conf=IDLE (4'b0000); busy=0; done=0; err=0; phase=0; counters=0; inverse latch=0.
- All outputs are registered. conf changes only on a clk edge.
- States: S_IDLE, S_RUN_A, S_DRAIN_A, S_RUN_B, S_DRAIN_B.
- Order by mode:
  - NTT: A = RADIX4_NTT, drain A = DONE_RADIX4_NTT; B = RADIX2_NTT, drain B = DONE_RADIX2_NTT.
  - INTT: A = RADIX2_INTT, drain A = DONE_RADIX2_INTT; B = RADIX4_INTT, drain B = DONE_RADIX4_INTT.
- S_IDLE: if start, latch inverse, clear counters, go to S_RUN_A. conf takes the RUN_A code at the same edge. busy=1 from that cycle.
- S_RUN_x, NTT mode:
  - Exit on done_flag matching the phase: 3'b010 for radix-4, 3'b001 for radix-2.
  - The next edge enters S_DRAIN_x with the DONE code.
  - A non-matching nonzero done_flag is ignored.
- S_RUN_x, INTT mode (FSM raises no flag):
  - Exit when the cycle counter reaches the phase length minus 1 (R4_CYCLES-1 or R2_CYCLES-1).
  - The counter starts at 0 on the first cycle conf shows the RUN code.
- Watchdog (NTT only): if the counter reaches phase length + WD_MARGIN without a matching flag, then:
  - err pulses once;
  - go to S_IDLE with conf=IDLE and busy=0;
  - done is not pulsed.
- S_DRAIN_x: hold the DONE code for exactly DRAINn cycles, counted from the first cycle it appears on conf.
  - After DRAIN_A, go to S_RUN_B.
  - After DRAIN_B, go to S_IDLE: done=1 for one cycle, coinciding with conf=IDLE and busy=0.
- conf never passes directly between two RUN codes; IDLE or DONE always separates them. This lets the FSM reinitialise its p/j/k/i counters.
- abort has priority over all other events, including a done_flag or a counter terminal in the same cycle. Result: S_IDLE, conf=IDLE, busy=0, no done, no err.
- start while busy is ignored; no queueing.
- start and abort in the same S_IDLE cycle: abort wins and start is dropped.
- Counter width is clog2(R4_CYCLES+WD_MARGIN+1). The counter saturates and never wraps.
- phase = 1 in RUN_A, 2 in RUN_B, 3 in either drain, 0 in idle.

Decomposition:
- Shared package ntt_pkg holds:
  - the conf code constants IDLE, RADIX2_NTT, RADIX4_NTT, DONE_RADIX2_NTT, DONE_RADIX4_NTT, RADIX4_INTT, RADIX2_INTT, DONE_RADIX2_INTT, DONE_RADIX4_INTT, using the existing 4-bit encodings;
  - the done_flag constants DONE_R2=3'b001 and DONE_R4=3'b010;
  - the scheduler state enum.
- One sub-module, phase_timer: loadable saturating up-counter with a terminal-compare output. It is used for RUN length, watchdog and drain hold.

Test Plan:
- NTT happy path: start=1, inverse=0, FSM model raises 3'b010 at cycle 512 and 3'b001 128 cycles into B.
  - Expected conf: 0010 x512, 0100 x14, 0001 x128, 0011 x8, then 0000.
  - done pulses once; busy high for exactly 662 cycles.
- INTT timed path: start with inverse=1.
  - Expected conf: 0110 x128, 0111 x8, 0101 x512, 1000 x14, then 0000.
  - done pulses once; done_flag held 0 throughout.
- Watchdog: NTT start with done_flag stuck 0.
  - err pulses at RUN_A cycle 528; conf returns to 0000; done never asserts.
- Abort mid-drain: assert abort on the 5th cycle of DONE_RADIX4_NTT.
  - Next cycle conf=0000, busy=0, done=0, err=0.
  - A new start is accepted on the following cycle.
- Async reset mid-RUN_B: drop rst during RUN_B.
  - conf=0000 and busy=0 immediately, without a clock edge.
  - After release, a start runs a full clean NTT sequence.
- Ignored inputs: start pulses while busy, and done_flag=3'b001 injected during RADIX4_NTT.
  - Sequence is unchanged: no early exit, no second run queued.
